// File: rtl/except_arbiter_nw.sv
// rtl/except_arbiter_nw.sv - N-way commit exception arbiter and redirect controller
module except_arbiter_nw #(
    parameter int          ISSUE_WIDTH     = 2,
    parameter int          INT_SYNC_STAGES = 2,
    parameter logic [31:0] BOOT_BASE       = 32'hbfc00200,
    parameter logic [31:0] NORMAL_BASE     = 32'h80000000,
    localparam int         SLOT_W          = (ISSUE_WIDTH > 1) ? $clog2(ISSUE_WIDTH) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [ISSUE_WIDTH-1:0]    commit_valid,
    input  logic [32*ISSUE_WIDTH-1:0] commit_pc,
    input  logic [ISSUE_WIDTH-1:0]    commit_delayslot,
    input  logic [ISSUE_WIDTH-1:0]    commit_is_priv,
    input  logic [ISSUE_WIDTH-1:0]    exc_occur,
    input  logic [ISSUE_WIDTH-1:0]    exc_eret,
    input  logic [5*ISSUE_WIDTH-1:0]  exc_code,
    input  logic [32*ISSUE_WIDTH-1:0] exc_extra,
    input  logic                      user_mode,
    input  logic                      st_ie,
    input  logic                      st_exl,
    input  logic                      st_erl,
    input  logic                      st_bev,
    input  logic                      cause_iv,
    input  logic [7:0]                st_im,
    input  logic [1:0]                ip_sw,
    input  logic [5:0]                hw_int,
    input  logic [31:0]               epc,
    input  logic [31:0]               error_epc,
    input  logic                      redirect_ready,
    output logic                      flush,
    output logic                      redirect_valid,
    output logic [31:0]               redirect_pc,
    output logic                      commit_stall,
    output logic [SLOT_W-1:0]         exc_slot,
    output logic [31:0]               cur_pc,
    output logic [31:0]               exc_extra_o,
    output logic [4:0]                exc_code_o,
    output logic                      eret_o,
    output logic                      delayslot_o,
    output logic [7:0]                ip_sync
);

    localparam logic [4:0] CODE_INT  = 5'd0;
    localparam logic [4:0] CODE_TLBL = 5'd2;
    localparam logic [4:0] CODE_TLBS = 5'd3;
    localparam logic [4:0] CODE_CPU  = 5'd11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FLUSH = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [INT_SYNC_STAGES-1:0][5:0] sync_q;
    logic                            int_pending;
    logic [ISSUE_WIDTH-1:0]          slot_fault;
    logic [ISSUE_WIDTH-1:0]          candidate;
    logic                            int_take;

    logic              sel_found;
    logic [SLOT_W-1:0] sel_slot;
    logic [31:0]       sel_pc;
    logic [31:0]       sel_extra;
    logic [4:0]        sel_code;
    logic              sel_eret;
    logic              sel_ds;

    logic [31:0]       vec_base;
    logic [15:0]       vec_offset;
    logic [31:0]       sel_target;

    // Shift the raw interrupt lines through the synchroniser chain; stage 0 is the first flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[INT_SYNC_STAGES-2:0], hw_int};
        end
    end

    // Software bits bypass the synchroniser; they are already in the clock domain.
    assign ip_sync     = {sync_q[INT_SYNC_STAGES-1], ip_sw};
    assign int_pending = st_ie & ~st_exl & ~st_erl & (|(ip_sync & st_im));

    // Per-slot fault flags; a pending interrupt is attached to the oldest valid slot instead.
    always_comb begin
        slot_fault = '0;
        for (int i = 0; i < ISSUE_WIDTH; i++) begin
            slot_fault[i] = commit_valid[i] &
                            (exc_occur[i] | exc_eret[i] | (user_mode & commit_is_priv[i]));
        end
        int_take  = int_pending & (|commit_valid);
        candidate = int_take ? commit_valid : slot_fault;
    end

    // Pick the oldest candidate slot and build the fields that will be registered for it.
    always_comb begin
        sel_found = 1'b0;
        sel_slot  = '0;
        sel_pc    = '0;
        sel_extra = '0;
        sel_code  = '0;
        sel_eret  = 1'b0;
        sel_ds    = 1'b0;
        for (int i = 0; i < ISSUE_WIDTH; i++) begin
            if (!sel_found && candidate[i]) begin
                sel_found = 1'b1;
                sel_slot  = SLOT_W'(i);
                sel_pc    = commit_pc[32*i +: 32];
                sel_ds    = commit_delayslot[i];
                if (int_take) begin
                    sel_code  = CODE_INT;
                    sel_extra = '0;
                    sel_eret  = 1'b0;
                end else if (user_mode && commit_is_priv[i]) begin
                    // Privilege violation outranks whatever the slot reported itself.
                    sel_code  = CODE_CPU;
                    sel_extra = 32'd1;
                    sel_eret  = 1'b0;
                end else begin
                    sel_code  = exc_code[5*i +: 5];
                    sel_extra = exc_extra[32*i +: 32];
                    sel_eret  = exc_eret[i];
                end
            end
        end
    end

    // Redirect target: return address for ERET, otherwise vector base plus offset.
    always_comb begin
        vec_base = st_bev ? BOOT_BASE : NORMAL_BASE;
        if (st_exl) begin
            vec_offset = 16'h0180;
        end else if ((sel_code == CODE_TLBL) || (sel_code == CODE_TLBS)) begin
            vec_offset = 16'h0000;
        end else if ((sel_code == CODE_INT) && cause_iv) begin
            vec_offset = 16'h0200;
        end else begin
            vec_offset = 16'h0180;
        end
        if (sel_eret) begin
            sel_target = st_erl ? error_epc : epc;
        end else begin
            sel_target = vec_base + {16'h0000, vec_offset};
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and control outputs; FLUSH lasts exactly one cycle.
    always_comb begin
        state_next     = state;
        flush          = 1'b0;
        redirect_valid = 1'b0;
        commit_stall   = 1'b0;
        case (state)
            IDLE: begin
                if (sel_found) begin
                    state_next = FLUSH;
                end
            end
            FLUSH: begin
                flush          = 1'b1;
                redirect_valid = 1'b1;
                commit_stall   = 1'b1;
                state_next     = redirect_ready ? IDLE : WAIT;
            end
            WAIT: begin
                redirect_valid = 1'b1;
                commit_stall   = 1'b1;
                if (redirect_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Capture the winner only on the IDLE decision cycle so outputs hold until acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exc_slot    <= '0;
            cur_pc      <= '0;
            exc_extra_o <= '0;
            exc_code_o  <= '0;
            eret_o      <= 1'b0;
            delayslot_o <= 1'b0;
            redirect_pc <= '0;
        end else if ((state == IDLE) && sel_found) begin
            exc_slot    <= sel_slot;
            cur_pc      <= sel_pc;
            exc_extra_o <= sel_extra;
            exc_code_o  <= sel_code;
            eret_o      <= sel_eret;
            delayslot_o <= sel_ds;
            redirect_pc <= sel_target;
        end
    end

endmodule
